pb_seq_player: RTL and testbench

//  Drives the four colour lamps (yel/re/blu/gre) to show the stored game sequence to the player.

---
 rtl/pb_seq_player.sv | 134 +++++++++++++
 tb/tb_pb_seq_player.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pb_seq_player.sv
// Plays a stored colour sequence on four lamps, one entry at a time.
// Each entry is fetched, shown for ON_CYCLES, then followed by an OFF_CYCLES dark gap.
module pb_seq_player #(
   parameter int unsigned MAX_LEN    = 32,
   parameter int unsigned IDX_W      = 5,
   parameter int unsigned ON_CYCLES  = 4,
   parameter int unsigned OFF_CYCLES = 2,
   parameter int unsigned CNT_W      = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [IDX_W:0]   len,
   output logic [IDX_W-1:0] rd_addr,
   input  logic [1:0]       rd_data,
   output logic             yel,
   output logic             re,
   output logic             blu,
   output logic             gre,
   output logic             busy,
   output logic             done
);

   localparam int unsigned LEN_W = IDX_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ON,
      S_OFF,
      S_FINISH
   } state_t;

   state_t             state, state_nx;
   logic [LEN_W-1:0]   len_q, len_nx;
   logic [LEN_W-1:0]   idx, idx_nx, idx_inc;
   logic [CNT_W-1:0]   timer, timer_nx;
   logic [3:0]         lamps, lamps_nx;
   logic [IDX_W-1:0]   rd_addr_nx;
   logic               busy_nx, done_nx;
   logic               timer_zero, last_entry;

   assign idx_inc    = idx + LEN_W'(1);
   assign timer_zero = (timer == '0);
   assign last_entry = (idx_inc == len_q);

   // Lamp vector order is {yel, re, blu, gre}, so code N lights bit 3-N.
   assign {yel, re, blu, gre} = lamps;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         len_q   <= '0;
         idx     <= '0;
         timer   <= '0;
         lamps   <= '0;
         rd_addr <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         len_q   <= len_nx;
         idx     <= idx_nx;
         timer   <= timer_nx;
         lamps   <= lamps_nx;
         rd_addr <= rd_addr_nx;
         busy    <= busy_nx;
         done    <= done_nx;
      end
   end

   // Next-state logic; abort outranks every other transition outside IDLE
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (start) state_nx = (len == '0) ? S_FINISH : S_FETCH;
         S_FETCH:  state_nx = S_ON;
         S_ON:     if (timer_zero) state_nx = S_OFF;
         S_OFF:    if (timer_zero) state_nx = last_entry ? S_FINISH : S_FETCH;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) state_nx = S_IDLE;
   end

   // Next values of registered outputs and datapath
   always_comb begin
      len_nx     = len_q;
      idx_nx     = idx;
      timer_nx   = timer;
      lamps_nx   = lamps;
      rd_addr_nx = rd_addr;
      busy_nx    = (state_nx != S_IDLE);
      done_nx    = (state_nx == S_FINISH);
      if (!timer_zero) timer_nx = timer - CNT_W'(1);

      unique case (state)
         S_IDLE: begin
            if (start) begin
               len_nx     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
               idx_nx     = '0;
               rd_addr_nx = '0;
            end
         end
         S_FETCH: begin
            lamps_nx = 4'b1000 >> rd_data;
            timer_nx = CNT_W'(ON_CYCLES - 1);
         end
         S_ON: begin
            if (timer_zero) begin
               lamps_nx = '0;
               timer_nx = CNT_W'(OFF_CYCLES - 1);
            end
         end
         S_OFF: begin
            if (timer_zero && !last_entry) begin
               idx_nx     = idx_inc;
               rd_addr_nx = idx_inc[IDX_W-1:0];
            end
         end
         default: ;
      endcase

      // Covers normal completion and abort alike
      if (state_nx == S_IDLE) begin
         lamps_nx = '0;
         idx_nx   = '0;
         timer_nx = '0;
      end
   end

endmodule

// File: tb/tb_pb_seq_player.sv
// Directed bench for pb_seq_player: reset, playback timing, lockout, abort, zero/clamp, all colours.
module tb_pb_seq_player;

   localparam int unsigned IDX_W = 5;
   localparam int P  = 7;   // 1 + ON + OFF
   localparam int ON = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [IDX_W:0]   len;
   logic [IDX_W-1:0] rd_addr;
   logic [1:0]       rd_data;
   logic             yel, re, blu, gre, busy, done;
   logic [1:0]       mem [32];

   int n_assert = 0;
   int n_fail   = 0;

   pb_seq_player #(
      .MAX_LEN(32), .IDX_W(IDX_W), .ON_CYCLES(4), .OFF_CYCLES(2), .CNT_W(24)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .yel(yel), .re(re), .blu(blu), .gre(gre), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   assign rd_data = mem[rd_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] lamp_of(input logic [1:0] code);
      logic [3:0] v;
      v = 4'b1000;
      return v >> code;
   endfunction

   // Start a playback and check every cycle against the expected timeline.
   // k is the number of edges since acceptance edge E0.
   task automatic play(input int n_req, input int n_exp, input bit relock, input bit with_abort);
      int e, r;
      logic [3:0] exp_l;
      len   = (IDX_W+1)'(n_req);
      start = 1'b1;
      abort = with_abort;
      tick();
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k <= n_exp * P + 2; k++) begin
         e = k / P;
         r = k % P;
         exp_l = 4'b0000;
         if (e < n_exp && r >= 1 && r <= ON) exp_l = lamp_of(mem[e]);
         chk($sformatf("lamps n=%0d k=%0d", n_exp, k), 32'({yel, re, blu, gre}), 32'(exp_l));
         chk($sformatf("done n=%0d k=%0d", n_exp, k), 32'(done), 32'(k == n_exp * P));
         chk($sformatf("busy n=%0d k=%0d", n_exp, k), 32'(busy), 32'(k <= n_exp * P));
         if (n_exp > 0)
            chk($sformatf("rd_addr n=%0d k=%0d", n_exp, k), 32'(rd_addr),
                32'((e < n_exp) ? e : n_exp - 1));
         if (relock && k == 9) begin start = 1'b1; len = 6'd1; end
         if (relock && k == 10) begin start = 1'b0; len = (IDX_W+1)'(n_req); end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      len   = '0;
      for (int i = 0; i < 32; i++) mem[i] = 2'b00;
      #1;
      chk("reset lamps", 32'({yel, re, blu, gre}), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset done", 32'(done), 32'h0);
      chk("reset rd_addr", 32'(rd_addr), 32'h0);
      #11 reset = 1'b0;
      tick();

      // Basic playback Y, R, G
      mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b11;
      play(3, 3, 1'b0, 1'b0);

      // Second start during playback (with a different len) is ignored
      play(3, 3, 1'b1, 1'b0);

      // Abort while red is lit
      len = 6'd3; start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      chk("pre-abort red", 32'({yel, re, blu, gre}), 32'h4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort lamps", 32'({yel, re, blu, gre}), 32'h0);
      chk("abort busy", 32'(busy), 32'h0);
      chk("abort done", 32'(done), 32'h0);
      begin
         int seen_done = 0;
         for (int k = 0; k < 30; k++) begin
            if (done || busy || yel || re || blu || gre) seen_done++;
            tick();
         end
         chk("abort stays idle", 32'(seen_done), 32'h0);
      end

      // Abort in IDLE has no effect
      abort = 1'b1; tick(); abort = 1'b0;
      chk("idle abort busy", 32'(busy), 32'h0);

      // Zero-length
      play(0, 0, 1'b0, 1'b0);

      // Clamp: len 40 plays 32 entries
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(3, 0));
      play(40, 32, 1'b0, 1'b0);

      // All colours, with abort raised together with start in IDLE
      mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b11;
      play(4, 4, 1'b0, 1'b1);

      // Asynchronous reset mid-playback, red lit
      mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b11;
      len = 6'd3; start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      chk("pre-reset red", 32'({yel, re, blu, gre}), 32'h4);
      chk("pre-reset rd_addr", 32'(rd_addr), 32'h1);
      #3 reset = 1'b1;
      #1;
      chk("async reset lamps", 32'({yel, re, blu, gre}), 32'h0);
      chk("async reset busy", 32'(busy), 32'h0);
      chk("async reset done", 32'(done), 32'h0);
      chk("async reset rd_addr", 32'(rd_addr), 32'h0);
      #2 reset = 1'b0;
      tick(); tick(); tick();
      chk("post-reset busy", 32'(busy), 32'h0);
      chk("post-reset lamps", 32'({yel, re, blu, gre}), 32'h0);

      // Fresh start after reset plays normally
      play(3, 3, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
